alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//   WIDTH-bit datapath ALU with a 4-bit status flag register {Z,C,N,O}.
//   Sits between register-file outputs A/B and the datapath result bus.
//   16 operations selected by FunSel.
//   Stored C flag is the carry-in for ADC, CSL and CSR.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (minimum 2)
// PORTS
//   Clock    in   1      rising-edge clock
//   Reset    in   1      synchronous, active-low reset
//   A        in   WIDTH  operand A
//   B        in   WIDTH  operand B
//   FunSel   in   4      operation select
//   OutALU   out  WIDTH  result
//   OutFlag  out  4      flag register: [3]=Z [2]=C [1]=N [0]=O
// BEHAVIOUR
//   - Reset is synchronous and active-low; clock is Clock.
//   - Reset: on a rising edge with Reset=0, OutFlag <= 4'b0000.
//   - OutALU is combinational from A, B, FunSel and the stored C flag.
//   - Flags are computed combinationally and registered on every rising edge.
//   - Flags not affected by the selected op keep their previous value.
//   - Z = (result==0) and N = result[MSB] update on every op.
//   - Operations (result; C/O effect, "-" = hold):
//       0000 A;   0001 B;   0010 ~A;   0011 ~B        C:-  O:-
//       0100 A+B        C=carry out   O=signed overflow
//       0101 A+B+C      C=carry out   O=signed overflow
//       0110 A-B, computed as A+~B+1
//                       C=carry out (1 = no borrow)   O=signed overflow
//       0111 A&B;  1000 A|B;  1001 A^B                C:-  O:-
//       1010 LSL  {A[W-2:0],0}    C=A[MSB]  O:-
//       1011 LSR  {0,A[W-1:1]}    C=A[0]    O:-
//       1100 ASL  {A[W-2:0],0}    C=A[MSB]  O=A[MSB]^A[MSB-1]
//       1101 ASR  {A[MSB],A[W-1:1]}   C:-  O:-
//       1110 CSL  {A[W-2:0],C}    C=A[MSB]  O:-
//       1111 CSR  {C,A[W-1:1]}    C=A[0]    O:-
//   - Signed overflow for add: operands have the same sign and the result sign differs.
//   - Signed overflow for sub: operand signs differ and the result sign differs from A.
//   - All arithmetic is modulo 2^WIDTH; the carry is bit WIDTH of a (WIDTH+1)-bit sum.
//   - ADC/CSL/CSR always read the registered C, never the C being computed this cycle.
//   - X or Z on FunSel: OutALU=0 and flags hold.
// CONFIGURATION
//   ALU_OUT_REG_EN
//     defined:   OutALU is registered; it updates on the same edge as OutFlag
//                (1-cycle latency) and resets to 0.
//     undefined: OutALU is purely combinational (0-cycle latency).
// STRUCTURE
//   - Package alu_pkg holds:
//       - FunSel localparams: OP_A, OP_B, OP_NOTA, OP_NOTB, OP_ADD, OP_ADC,
//         OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_LSR, OP_ASL, OP_ASR,
//         OP_CSL, OP_CSR
//       - flag index constants: FLG_Z=3, FLG_C=2, FLG_N=1, FLG_O=0
//   - One sub-module, alu_shifter: combinational.
//       - inputs: A, carry-in, 2-bit shift kind, direction
//       - outputs: result, shifted-out bit
//   - Adder, logic ops and flag register live in alu_core.
// TESTING
//   1. Reset=0 for one edge -> OutFlag=0000.
//      Then Reset=1, FunSel=0000, A=0x00 -> OutALU=0x00; after edge Z=1, OutFlag=1000.
//   2. A=0x7F, B=0x01, FunSel=0100 -> OutALU=0x80; after edge OutFlag=0011 (N=1, O=1).
//   3. A=0x7F, B=0x01, FunSel=0110 -> OutALU=0x7E; after edge OutFlag=0100 (C=1, no borrow).
//   4. C=1 stored, A=0x7F, B=0x01, FunSel=0101 -> OutALU=0x81; after edge OutFlag=0011.
//   5. C=1 stored, A=0x80, FunSel=1110 -> OutALU=0x01, C=1.
//      Then FunSel=1111, A=0x01 -> OutALU=0x80, C=1, N=1.
//   6. C=1 stored, A=B=0xFF, FunSel=1001 -> OutALU=0x00, Z=1, C stays 1, O held.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_core datapath ALU: FunSel opcodes,
// flag bit positions inside OutFlag, and the shifter control encoding.
package alu_pkg;

    // FunSel operation codes
    localparam logic [3:0] OP_A    = 4'b0000;
    localparam logic [3:0] OP_B    = 4'b0001;
    localparam logic [3:0] OP_NOTA = 4'b0010;
    localparam logic [3:0] OP_NOTB = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADC  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_LSL  = 4'b1010;
    localparam logic [3:0] OP_LSR  = 4'b1011;
    localparam logic [3:0] OP_ASL  = 4'b1100;
    localparam logic [3:0] OP_ASR  = 4'b1101;
    localparam logic [3:0] OP_CSL  = 4'b1110;
    localparam logic [3:0] OP_CSR  = 4'b1111;

    // Bit positions inside the {Z,C,N,O} flag register
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_O = 0;

    // What fills the vacated bit position of a one-bit shift
    typedef enum logic [1:0] {
        SH_LOGIC = 2'd0,  // zero fill
        SH_ARITH = 2'd1,  // sign fill on right shifts, zero fill on left
        SH_CARRY = 2'd2   // stored carry flag fills the vacated bit
    } shift_kind_e;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } shift_dir_e;

    // Shift opcodes come in left/right pairs; bits [2:1] select the kind
    // and bit [0] the direction.
    function automatic shift_kind_e shift_kind_of(input logic [3:0] fun_sel);
        shift_kind_e kind;
        case (fun_sel[2:1])
            2'b10:   kind = SH_ARITH;
            2'b11:   kind = SH_CARRY;
            default: kind = SH_LOGIC;
        endcase
        return kind;
    endfunction

    function automatic shift_dir_e shift_dir_of(input logic [3:0] fun_sel);
        return fun_sel[0] ? SH_RIGHT : SH_LEFT;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// One-bit shifter for alu_core. Purely combinational: shifts a_i one place
// left or right, choosing the fill bit by shift kind, and reports the bit
// that falls off the end so the caller can load it into the carry flag.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             carry_i,
    input  shift_kind_e      kind_i,
    input  shift_dir_e       dir_i,
    output logic [WIDTH-1:0] result_o,
    output logic             shift_out_o
);

    logic fill;

    // Pick the fill bit and form the shifted word
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves a value unassigned and infers a latch.
        fill        = 1'b0;
        result_o    = '0;
        shift_out_o = 1'b0;
        if (dir_i == SH_LEFT) begin
            fill        = (kind_i == SH_CARRY) ? carry_i : 1'b0;
            result_o    = {a_i[WIDTH-2:0], fill};
            shift_out_o = a_i[WIDTH-1];
        end else begin
            case (kind_i)
                SH_ARITH: fill = a_i[WIDTH-1];
                SH_CARRY: fill = carry_i;
                default:  fill = 1'b0;
            endcase
            result_o    = {fill, a_i[WIDTH-1:1]};
            shift_out_o = a_i[0];
        end
    end

endmodule

// File: rtl/alu_core.sv
// WIDTH-bit datapath ALU with a registered {Z,C,N,O} status flag register.
// The result is combinational from A, B, FunSel and the stored carry; the
// flags are recomputed every cycle and captured on the rising Clock edge.
// Ops that do not define C or O leave those flags unchanged. ADC, CSL and
// CSR always consume the registered carry, never the one being computed.
// Build option ALU_OUT_REG_EN: when defined, OutALU is registered on the
// same edge as OutFlag (one cycle of latency) and resets to zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FunSel,
    output logic [WIDTH-1:0] OutALU,
    output logic [3:0]       OutFlag
);

    localparam int MSB = WIDTH - 1;

    logic [3:0]       flag_q;
    logic [3:0]       flag_d;
    logic             carry_q;

    logic [WIDTH-1:0] alu_res;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic             add_ovf;

    logic [WIDTH-1:0] sh_res;
    logic             sh_out;

    assign carry_q = flag_q[FLG_C];

    // Shared adder: ADD and ADC add B, SUB adds ~B with a forced carry-in
    always_comb begin
        add_b   = B;
        add_cin = 1'b0;
        case (FunSel)
            OP_ADC: add_cin = carry_q;
            OP_SUB: begin
                add_b   = ~B;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    // Both operands entering the adder share a sign that the sum does not.
    // With add_b = ~B this is exactly the subtract rule: A and B differ in
    // sign and the difference differs in sign from A.
    assign add_ovf = (A[MSB] == add_b[MSB]) && (add_sum[MSB] != A[MSB]);

    alu_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .a_i        (A),
        .carry_i    (carry_q),
        .kind_i     (shift_kind_of(FunSel)),
        .dir_i      (shift_dir_of(FunSel)),
        .result_o   (sh_res),
        .shift_out_o(sh_out)
    );

    // Select the result and work out the next flag register value
    always_comb begin
        alu_res = '0;
        flag_d  = flag_q;
        case (FunSel)
            OP_A:    alu_res = A;
            OP_B:    alu_res = B;
            OP_NOTA: alu_res = ~A;
            OP_NOTB: alu_res = ~B;
            OP_ADD, OP_ADC, OP_SUB: begin
                alu_res       = add_sum[MSB:0];
                flag_d[FLG_C] = add_sum[WIDTH];
                flag_d[FLG_O] = add_ovf;
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_LSL, OP_LSR, OP_CSL, OP_CSR: begin
                alu_res       = sh_res;
                flag_d[FLG_C] = sh_out;
            end
            OP_ASL: begin
                alu_res       = sh_res;
                flag_d[FLG_C] = sh_out;
                flag_d[FLG_O] = A[MSB] ^ A[MSB-1];
            end
            OP_ASR:  alu_res = sh_res;
            default: alu_res = '0;
        endcase

        // Z and N follow the result on every defined op; an unknown FunSel
        // lands in the default arm above and leaves every flag held.
        case (FunSel)
            OP_A, OP_B, OP_NOTA, OP_NOTB, OP_ADD, OP_ADC, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_LSL, OP_LSR, OP_ASL, OP_ASR, OP_CSL, OP_CSR: begin
                flag_d[FLG_Z] = (alu_res == '0);
                flag_d[FLG_N] = alu_res[MSB];
            end
            default: ;
        endcase
    end

    // Flag register with synchronous active-low reset
    always_ff @(posedge Clock) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples its inputs from before the edge, independent of block order.
        if (!Reset) begin
            flag_q <= 4'b0000;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign OutFlag = flag_q;

`ifdef ALU_OUT_REG_EN
    logic [WIDTH-1:0] out_q;

    // Result register, captured on the same edge as the flags
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            out_q <= '0;
        end else begin
            out_q <= alu_res;
        end
    end

    assign OutALU = out_q;
`else
    assign OutALU = alu_res;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (WIDTH=8). Expected results are pushed to
// a scoreboard queue when each operation is driven and popped for comparison
// when the DUT produces it: before the edge for a combinational OutALU, after
// it for OutFlag (and for OutALU when ALU_OUT_REG_EN is defined).
module tb_alu_core;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] alu;
        logic [3:0] flg;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] FunSel;
    logic [7:0] OutALU;
    logic [3:0] OutFlag;

    exp_t       sb_q[$];
    logic [3:0] m_flg;
    int         vectors = 0;
    int         miscompares = 0;

    alu_core #(
        .WIDTH(8)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .A      (A),
        .B      (B),
        .FunSel (FunSel),
        .OutALU (OutALU),
        .OutFlag(OutFlag)
    );

    always #5 Clock = ~Clock;

    // Reference behaviour of one operation, written straight from the op table
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] fs, input logic [3:0] fin,
                                  output logic [7:0] r, output logic [3:0] fout);
        logic       c;
        logic       o;
        logic [8:0] t;
        c = fin[2];
        o = fin[0];
        r = 8'h00;
        t = 9'h000;
        case (fs)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = ~a;
            4'h3: r = ~b;
            4'h4: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[7:0];
                c = t[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h5: begin
                t = {1'b0, a} + {1'b0, b} + {8'h00, fin[2]};
                r = t[7:0];
                c = t[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h6: begin
                t = {1'b0, a} + {1'b0, ~b} + 9'h001;
                r = t[7:0];
                c = t[8];
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h7: r = a & b;
            4'h8: r = a | b;
            4'h9: r = a ^ b;
            4'ha: begin r = {a[6:0], 1'b0};   c = a[7]; end
            4'hb: begin r = {1'b0, a[7:1]};   c = a[0]; end
            4'hc: begin r = {a[6:0], 1'b0};   c = a[7]; o = a[7] ^ a[6]; end
            4'hd: r = {a[7], a[7:1]};
            4'he: begin r = {a[6:0], fin[2]}; c = a[7]; end
            default: begin r = {fin[2], a[7:1]}; c = a[0]; end
        endcase
        fout = {(r == 8'h00), c, r[7], o};
    endfunction

    task automatic push_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fs);
        exp_t e;
        logic [7:0] r;
        logic [3:0] nf;
        model(a, b, fs, m_flg, r, nf);
        m_flg = nf;
        e.alu = r;
        e.flg = nf;
        sb_q.push_back(e);
    endtask

    task automatic push_const(input logic [7:0] alu, input logic [3:0] flg);
        exp_t e;
        e.alu = alu;
        e.flg = flg;
        m_flg = flg;
        sb_q.push_back(e);
    endtask

    // Drive one operation, check it against the scoreboard head, retire it
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fs,
                       input string tag);
        exp_t e;
        A      = a;
        B      = b;
        FunSel = fs;
        #2;
`ifndef ALU_OUT_REG_EN
        vectors++;
        if (OutALU !== sb_q[0].alu) begin
            miscompares++;
            $display("FAIL %s OutALU: got %h expected %h", tag, OutALU, sb_q[0].alu);
        end
`endif
        @(posedge Clock);
        #1;
        e = sb_q.pop_front();
`ifdef ALU_OUT_REG_EN
        vectors++;
        if (OutALU !== e.alu) begin
            miscompares++;
            $display("FAIL %s OutALU: got %h expected %h", tag, OutALU, e.alu);
        end
`endif
        vectors++;
        if (OutFlag !== e.flg) begin
            miscompares++;
            $display("FAIL %s OutFlag: got %b expected %b", tag, OutFlag, e.flg);
        end
    endtask

    task automatic test_reset;
        Reset  = 1'b0;
        A      = 8'h55;
        B      = 8'hAA;
        FunSel = OP_ADD;
        @(posedge Clock);
        #1;
        m_flg = 4'b0000;
        vectors++;
        if (OutFlag !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset OutFlag: got %b expected 0000", OutFlag);
        end
`ifdef ALU_OUT_REG_EN
        vectors++;
        if (OutALU !== 8'h00) begin
            miscompares++;
            $display("FAIL reset OutALU: got %h expected 00", OutALU);
        end
`endif
        Reset = 1'b1;
        push_const(8'h00, 4'b1000);
        run(8'h00, 8'h00, OP_A, "pass_a_zero");
    endtask

    task automatic test_arith;
        push_const(8'h80, 4'b0011);
        run(8'h7F, 8'h01, OP_ADD, "add_ovf");
        push_const(8'h7E, 4'b0100);
        run(8'h7F, 8'h01, OP_SUB, "sub_noborrow");
        push_const(8'h81, 4'b0011);
        run(8'h7F, 8'h01, OP_ADC, "adc_cin1");
        push_const(8'h00, 4'b1100);
        run(8'hFF, 8'h01, OP_ADD, "add_wrap");
        push_const(8'hFF, 4'b0010);
        run(8'h00, 8'h01, OP_SUB, "sub_borrow");
        push_const(8'h7F, 4'b0101);
        run(8'h80, 8'h01, OP_SUB, "sub_ovf");
    endtask

    task automatic test_shift;
        push_const(8'h00, 4'b1100);
        run(8'hFF, 8'h01, OP_ADD, "set_carry");
        push_const(8'h01, 4'b0100);
        run(8'h80, 8'h00, OP_CSL, "csl_cin");
        push_const(8'h80, 4'b0110);
        run(8'h01, 8'h00, OP_CSR, "csr_cin");
        push_model(8'hC3, 8'h00, OP_LSL);
        run(8'hC3, 8'h00, OP_LSL, "lsl");
        push_model(8'hC3, 8'h00, OP_LSR);
        run(8'hC3, 8'h00, OP_LSR, "lsr");
        push_model(8'h40, 8'h00, OP_ASL);
        run(8'h40, 8'h00, OP_ASL, "asl_ovf");
        push_model(8'h81, 8'h00, OP_ASR);
        run(8'h81, 8'h00, OP_ASR, "asr_sign");
    endtask

    task automatic test_logic;
        push_const(8'h80, 4'b0011);
        run(8'h7F, 8'h01, OP_ADD, "set_ovf");
        push_const(8'h7F, 4'b0101);
        run(8'h80, 8'h01, OP_SUB, "set_carry_ovf");
        push_const(8'h00, 4'b1101);
        run(8'hFF, 8'hFF, OP_XOR, "xor_hold_co");
        push_model(8'hF0, 8'h3C, OP_AND);
        run(8'hF0, 8'h3C, OP_AND, "and");
        push_model(8'hF0, 8'h0C, OP_OR);
        run(8'hF0, 8'h0C, OP_OR, "or");
        push_model(8'h5A, 8'h00, OP_NOTA);
        run(8'h5A, 8'h00, OP_NOTA, "nota");
        push_model(8'h00, 8'hFF, OP_NOTB);
        run(8'h00, 8'hFF, OP_NOTB, "notb_zero");
        push_model(8'h12, 8'h9C, OP_B);
        run(8'h12, 8'h9C, OP_B, "pass_b");
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fs;
        for (int i = 0; i < 80; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            fs = 4'($urandom_range(0, 15));
            push_model(a, b, fs);
            run(a, b, fs, "random");
        end
    endtask

    initial begin
        m_flg = 4'b0000;
        test_reset();
        test_arith();
        test_shift();
        test_logic();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
